// File: rtl/multi_neuron_decay_engine.sv
// multi_neuron_decay_engine
// Bank of NUM_NEURONS signed membrane potentials, each with its own decay
// mode. A time_step pulse in IDLE starts one sweep: every neuron in index
// order is decayed (CALC), written back, and presented on the out_* port
// until the consumer accepts it (EMIT). done pulses in the first IDLE cycle
// after the last handshake.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   load_valid/ready    load handshake (ready only in IDLE)
//   load_addr/data/mode neuron index, new potential, decay mode
//   time_step           single-cycle sweep trigger
//   busy                sweep in progress
//   out_valid/ready     decayed-potential handshake
//   out_addr/data       neuron index and its decayed potential
//   done                one-cycle pulse at sweep end
//   overrun             sticky: time_step seen while busy
module multi_neuron_decay_engine #(
    parameter int DATA_W      = 32,
    parameter int NUM_NEURONS = 16,
    parameter int ADDR_W      = 4,
    parameter int FRAC_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic [2:0]        load_mode,
    input  logic              time_step,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              done,
    output logic              overrun
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_EMIT = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_NEURONS - 1);
    localparam logic [ADDR_W:0]   DEPTH    = (ADDR_W + 1)'(NUM_NEURONS);
    localparam logic [DATA_W-1:0] SAT_MAX  = {1'b0, {(DATA_W - 1){1'b1}}};
    // Same saturation limit, widened for comparison against the QUAD product.
    localparam logic signed [2*DATA_W-1:0] SAT_MAX_W =
        {{(DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};

    // Decay function for one potential under a given mode.
    function automatic logic [DATA_W-1:0] decay(input logic [DATA_W-1:0] v,
                                                input logic [2:0]        m);
        logic signed [DATA_W-1:0]   sv;
        logic signed [2*DATA_W-1:0] ext;
        logic signed [2*DATA_W-1:0] prod;
        logic signed [2*DATA_W-1:0] quad;
        logic        [DATA_W-1:0]   r;
        sv   = $signed(v);
        // Sign-extend so the truncated 2*DATA_W product is the exact square.
        ext  = {{DATA_W{v[DATA_W-1]}}, v};
        prod = ext * ext;
        quad = prod >>> FRAC_W;
        case (m)
            3'd0:    r = v;
            3'd1:    r = sv >>> 1;
            3'd2:    r = sv >>> 2;
            3'd3:    r = sv >>> 3;
            3'd4:    r = (sv >>> 1) + (sv >>> 2);
            3'd5:    r = sv - (sv >>> 3);
            // A square is never negative, so only the upper bound matters.
            3'd6:    r = (quad > SAT_MAX_W) ? SAT_MAX : quad[DATA_W-1:0];
            3'd7:    r = '0;
            default: r = v;
        endcase
        return r;
    endfunction

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   pot_q  [NUM_NEURONS];
    logic [2:0]          mode_q [NUM_NEURONS];
    logic [ADDR_W-1:0]   idx_q;
    logic [ADDR_W-1:0]   out_addr_q;
    logic [DATA_W-1:0]   out_data_q;
    logic                done_q;
    logic                overrun_q;
    logic [DATA_W-1:0]   decayed_d;
    logic                load_fire_s;
    logic                addr_ok_s;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (time_step) state_d = S_CALC;
                else           state_d = S_IDLE;
            end
            S_CALC: state_d = S_EMIT;
            S_EMIT: begin
                if (out_ready) state_d = (idx_q == LAST_IDX) ? S_IDLE : S_CALC;
                else           state_d = S_EMIT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs decoded from the registered state.
    always_comb begin
        load_ready = 1'b0;
        busy       = 1'b1;
        out_valid  = 1'b0;
        case (state_q)
            S_IDLE: begin
                load_ready = 1'b1;
                busy       = 1'b0;
            end
            S_CALC: begin
                busy = 1'b1;
            end
            S_EMIT: begin
                out_valid = 1'b1;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

    // Load qualification and decay of the neuron currently addressed.
    always_comb begin
        load_fire_s = load_valid & (state_q == S_IDLE);
        // Out-of-range indices are accepted but dropped.
        addr_ok_s   = ({1'b0, load_addr} < DEPTH);
        decayed_d   = decay(pot_q[idx_q], mode_q[idx_q]);
    end

    // Datapath: bank storage, sweep index, output registers, flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                pot_q[i]  <= '0;
                mode_q[i] <= 3'd0;
            end
            idx_q      <= '0;
            out_addr_q <= '0;
            out_data_q <= '0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // Load only happens in IDLE, so it never collides with write-back.
            if (load_fire_s && addr_ok_s) begin
                pot_q[load_addr]  <= load_data;
                mode_q[load_addr] <= load_mode;
            end
            if (time_step && (state_q != S_IDLE)) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (time_step) idx_q <= '0;
                end
                S_CALC: begin
                    pot_q[idx_q] <= decayed_d;
                    out_data_q   <= decayed_d;
                    out_addr_q   <= idx_q;
                end
                S_EMIT: begin
                    if (out_ready) begin
                        if (idx_q == LAST_IDX) done_q <= 1'b1;
                        else                   idx_q  <= idx_q + 1'b1;
                    end
                end
                default: begin
                    idx_q <= '0;
                end
            endcase
        end
    end

    assign out_addr = out_addr_q;
    assign out_data = out_data_q;
    assign done     = done_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_multi_neuron_decay_engine.sv
// Directed bench for multi_neuron_decay_engine: stimulus pushes hand-computed
// expected (addr, data) pairs into a queue; a negedge monitor pops and
// compares on every output handshake and checks stability while stalled.
module tb_multi_neuron_decay_engine;

    localparam int DW = 32;
    localparam int NN = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_valid = 1'b0;
    logic          load_ready;
    logic [AW-1:0] load_addr = '0;
    logic [DW-1:0] load_data = '0;
    logic [2:0]    load_mode = 3'd0;
    logic          time_step = 1'b0;
    logic          busy;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] out_data;
    logic          done;
    logic          overrun;

    multi_neuron_decay_engine #(
        .DATA_W(DW), .NUM_NEURONS(NN), .ADDR_W(AW), .FRAC_W(8)
    ) dut (
        .clk(clk), .rst(rst),
        .load_valid(load_valid), .load_ready(load_ready),
        .load_addr(load_addr), .load_data(load_data), .load_mode(load_mode),
        .time_step(time_step), .busy(busy),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_data(out_data),
        .done(done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int                n_checks = 0;
    int                n_pass   = 0;
    int                cyc      = 0;
    int                last_hs_cyc = 0;
    logic [AW+DW-1:0]  exp_q[$];
    logic [AW+DW-1:0]  ent;
    logic [DW-1:0]     exp_tab [NN];
    logic              rand_stall = 1'b0;
    logic              stall_pend = 1'b0;
    logic [AW-1:0]     held_addr;
    logic [DW-1:0]     held_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // out_ready driver: held high, or randomly stalled.
    initial forever begin
        @(posedge clk);
        #1;
        out_ready = rand_stall ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    // Monitor / scoreboard.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            stall_pend = 1'b0;
        end else if (out_valid) begin
            if (stall_pend) begin
                chk("stall_addr", 32'(out_addr), 32'(held_addr));
                chk("stall_data", out_data, held_data);
            end
            if (out_ready) begin
                stall_pend  = 1'b0;
                last_hs_cyc = cyc;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_out: got addr %0d data 0x%08h, expected none",
                             out_addr, out_data);
                end else begin
                    ent = exp_q.pop_front();
                    chk("out_addr", 32'(out_addr), 32'(ent[AW+DW-1:DW]));
                    chk("out_data", out_data, ent[DW-1:0]);
                end
            end else begin
                stall_pend = 1'b1;
                held_addr  = out_addr;
                held_data  = out_data;
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        time_step = 1'b0;
        load_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_load_ready", 32'(load_ready), 32'd1);
        chk("rst_busy",       32'(busy),       32'd0);
        chk("rst_out_valid",  32'(out_valid),  32'd0);
        chk("rst_out_addr",   32'(out_addr),   32'd0);
        chk("rst_out_data",   out_data,        32'd0);
        chk("rst_done",       32'(done),       32'd0);
        chk("rst_overrun",    32'(overrun),    32'd0);
        exp_q.delete();
        rst = 1'b0;
    endtask

    task automatic do_load(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [2:0] m);
        @(posedge clk);
        #1;
        load_valid = 1'b1;
        load_addr  = a;
        load_data  = d;
        load_mode  = m;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
    endtask

    task automatic run_sweep(input string tag, input bit lat_chk, input bit inject, input bit sim_load);
        int waited;
        bit got;
        for (int i = 0; i < NN; i++) exp_q.push_back({AW'(i), exp_tab[i]});
        @(posedge clk);
        #1;
        time_step = 1'b1;
        if (sim_load) begin
            load_valid = 1'b1;
            load_addr  = 4'd0;
            load_data  = 32'h0000_0200;
            load_mode  = 3'd1;
        end
        @(posedge clk);
        #1;
        time_step  = 1'b0;
        load_valid = 1'b0;
        if (lat_chk) begin
            chk("lat_busy",   32'(busy),      32'd1);
            chk("lat_valid0", 32'(out_valid), 32'd0);
            @(posedge clk);
            #1;
            chk("lat_valid1", 32'(out_valid), 32'd1);
            chk("lat_addr0",  32'(out_addr),  32'd0);
        end
        if (inject) begin
            repeat (5) @(posedge clk);
            #1;
            chk("mid_load_ready", 32'(load_ready), 32'd0);
            time_step  = 1'b1;
            load_valid = 1'b1;
            load_addr  = 4'd5;
            load_data  = 32'h0000_0555;
            load_mode  = 3'd0;
            @(posedge clk);
            #1;
            time_step  = 1'b0;
            load_valid = 1'b0;
        end
        got = 1'b0;
        waited = 0;
        while (!got && waited < 400) begin
            if (done) got = 1'b1;
            else begin
                @(posedge clk);
                #1;
                waited++;
            end
        end
        if (!got) begin
            n_checks++;
            $display("FAIL %s_done_timeout: got no done within 400 cycles, expected done", tag);
        end else begin
            chk({tag, "_done_cycle"}, 32'(cyc), 32'(last_hs_cyc + 1));
            chk({tag, "_done_ready"}, 32'(load_ready), 32'd1);
            chk({tag, "_done_busy"},  32'(busy), 32'd0);
            chk({tag, "_all_out"},    32'(exp_q.size()), 32'd0);
            @(posedge clk);
            #1;
            chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        end
        exp_q.delete();
    endtask

    initial begin
        int waited;
        do_reset();

        // Basic LIF2 / LIF4 over two sweeps.
        do_load(4'd0, 32'h0000_0100, 3'd1);
        do_load(4'd1, 32'hFFFF_FF00, 3'd2);
        exp_tab = '{0: 32'h0000_0080, 1: 32'hFFFF_FFC0, default: 32'h0};
        run_sweep("sw1", 1'b1, 1'b0, 1'b0);
        exp_tab = '{0: 32'h0000_0040, 1: 32'hFFFF_FFF0, default: 32'h0};
        run_sweep("sw2", 1'b0, 1'b0, 1'b0);

        // Remaining modes, including QUAD and its saturation.
        do_reset();
        do_load(4'd2, 32'h0000_0100, 3'd4);
        do_load(4'd3, 32'h0000_0100, 3'd5);
        do_load(4'd4, 32'h0000_0100, 3'd7);
        do_load(4'd5, 32'h0000_0100, 3'd0);
        do_load(4'd6, 32'h0000_0100, 3'd6);
        do_load(4'd7, 32'h0000_1000, 3'd6);
        do_load(4'd8, 32'h7FFF_FFFF, 3'd6);
        exp_tab = '{2: 32'h0000_00C0, 3: 32'h0000_00E0, 5: 32'h0000_0100,
                    6: 32'h0000_0100, 7: 32'h0001_0000, 8: 32'h7FFF_FFFF,
                    default: 32'h0};
        run_sweep("sw3", 1'b0, 1'b0, 1'b0);

        // Same bank under random backpressure.
        rand_stall = 1'b1;
        exp_tab = '{2: 32'h0000_0090, 3: 32'h0000_00C4, 5: 32'h0000_0100,
                    6: 32'h0000_0100, 7: 32'h0100_0000, 8: 32'h7FFF_FFFF,
                    default: 32'h0};
        run_sweep("sw4", 1'b0, 1'b0, 1'b0);

        // time_step and load while busy: overrun set, no write, sweep intact.
        exp_tab = '{2: 32'h0000_006C, 3: 32'h0000_00AC, 5: 32'h0000_0100,
                    6: 32'h0000_0100, 7: 32'h7FFF_FFFF, 8: 32'h7FFF_FFFF,
                    default: 32'h0};
        run_sweep("sw5", 1'b0, 1'b1, 1'b0);
        chk("overrun_set", 32'(overrun), 32'd1);
        rand_stall = 1'b0;

        // Load and time_step in the same IDLE cycle; n5 must still hold 0x100.
        exp_tab = '{0: 32'h0000_0100, 2: 32'h0000_0051, 3: 32'h0000_0097,
                    5: 32'h0000_0100, 6: 32'h0000_0100, 7: 32'h7FFF_FFFF,
                    8: 32'h7FFF_FFFF, default: 32'h0};
        run_sweep("sw6", 1'b0, 1'b0, 1'b1);
        chk("overrun_sticky", 32'(overrun), 32'd1);

        // Reset while neuron 5 is being presented.
        exp_q.push_back({4'd0, 32'h0000_0080});
        exp_q.push_back({4'd1, 32'h0000_0000});
        exp_q.push_back({4'd2, 32'h0000_003C});
        exp_q.push_back({4'd3, 32'h0000_0085});
        exp_q.push_back({4'd4, 32'h0000_0000});
        @(posedge clk);
        #1;
        time_step = 1'b1;
        @(posedge clk);
        #1;
        time_step = 1'b0;
        waited = 0;
        while (!(out_valid && out_addr == 4'd5) && waited < 400) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (waited >= 400) begin
            n_checks++;
            $display("FAIL reach_n5: got no neuron 5 within 400 cycles, expected it");
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mrst_busy",      32'(busy),       32'd0);
        chk("mrst_out_valid", 32'(out_valid),  32'd0);
        chk("mrst_done",      32'(done),       32'd0);
        chk("mrst_overrun",   32'(overrun),    32'd0);
        chk("mrst_ready",     32'(load_ready), 32'd1);
        chk("mrst_seen_0_4",  32'(exp_q.size()), 32'd0);
        exp_q.delete();
        rst = 1'b0;

        // Bank was cleared by reset: everything decays to zero.
        exp_tab = '{default: 32'h0};
        run_sweep("sw7", 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation time limit, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
